// File: rtl/mdio_controller.sv
// MDIO management master: Clause 22 / Clause 45 frames with valid/ready command and response streams.
module mdio_controller #(
  parameter int unsigned CLKS_PER_HALF_MDC = 62,
  parameter int unsigned PREAMBLE_BITS     = 32,
  parameter bit          SUPPORT_CLAUSE45  = 1'b1,
  parameter int unsigned IDLE_GAP_BITS     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_c45,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        busy,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t
);

  localparam int unsigned BIT_CLKS = 2 * CLKS_PER_HALF_MDC;
  localparam int unsigned CW       = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] RISE_AT  = CW'(CLKS_PER_HALF_MDC - 1);
  localparam logic [CW-1:0] END_AT   = CW'(BIT_CLKS - 1);
  localparam logic [15:0]   PRE_LAST = 16'(PREAMBLE_BITS - 1);
  localparam logic [15:0]   GAP_LAST = 16'(IDLE_GAP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_HEADER, S_TA, S_DATA, S_RESP, S_GAP, S_REJECT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   bitn_q, bitn_d;
  logic [31:0]   tx_q, tx_d;
  logic          rd_q, rd_d;
  logic          gap_done_q, gap_done_d;
  logic          mdc_q, mdc_d;
  logic          mdio_o_q, mdio_o_d;
  logic          mdio_t_q, mdio_t_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_data_q, rsp_data_d;
  logic          rsp_error_q, rsp_error_d;
  logic          busy_q, busy_d;

  logic [31:0] frame_w;
  logic        cmd_bad;
  logic        bit_end, rise, in_frame, gap_run, rsp_take;

  // ST, OP, PHYAD, REGAD, write turnaround (10), data: shifted out MSB first after the preamble
  assign frame_w  = {1'b0, ~cmd_c45, cmd_op, cmd_phy_addr, cmd_reg_addr, 2'b10, cmd_data};
  assign cmd_bad  = (cmd_c45 && !SUPPORT_CLAUSE45) ||
                    (!cmd_c45 && (cmd_op == 2'b00 || cmd_op == 2'b11));
  assign bit_end  = (cnt_q == END_AT);
  assign rise     = (cnt_q == RISE_AT);
  assign in_frame = state_q inside {S_PREAMBLE, S_HEADER, S_TA, S_DATA};
  assign gap_run  = (state_q inside {S_RESP, S_GAP}) && !gap_done_q;
  assign rsp_take = rsp_valid_q && rsp_ready;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      tx_q        <= '0;
      rd_q        <= 1'b0;
      gap_done_q  <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_o_q    <= 1'b0;
      mdio_t_q    <= 1'b1;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitn_q      <= bitn_d;
      tx_q        <= tx_d;
      rd_q        <= rd_d;
      gap_done_q  <= gap_done_d;
      mdc_q       <= mdc_d;
      mdio_o_q    <= mdio_o_d;
      mdio_t_q    <= mdio_t_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, bit timing and pad drive; pad values are set on the edge that starts each bit
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitn_d      = bitn_q;
    tx_d        = tx_q;
    rd_d        = rd_q;
    gap_done_d  = gap_done_q;
    mdc_d       = mdc_q;
    mdio_o_d    = mdio_o_q;
    mdio_t_d    = mdio_t_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;

    if (in_frame || gap_run) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
      if (rise)    mdc_d = 1'b1;
      if (bit_end) mdc_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        mdc_d    = 1'b0;
        mdio_t_d = 1'b1;
        mdio_o_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b0;
          rd_d        = cmd_op[1];
          bitn_d      = '0;
          gap_done_d  = 1'b0;
          if (cmd_bad) begin
            state_d     = S_REJECT;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            mdio_t_d = 1'b0;
            if (PREAMBLE_BITS != 0) begin
              state_d  = S_PREAMBLE;
              tx_d     = frame_w;
              mdio_o_d = 1'b1;
            end else begin
              state_d  = S_HEADER;
              tx_d     = {frame_w[30:0], 1'b0};
              mdio_o_d = frame_w[31];
            end
          end
        end
      end

      S_PREAMBLE: begin
        if (bit_end) begin
          if (bitn_q == PRE_LAST) begin
            state_d  = S_HEADER;
            bitn_d   = '0;
            mdio_o_d = tx_q[31];
            tx_d     = {tx_q[30:0], 1'b0};
          end else begin
            bitn_d   = bitn_q + 16'd1;
            mdio_o_d = 1'b1;
          end
        end
      end

      S_HEADER: begin
        if (bit_end) begin
          tx_d = {tx_q[30:0], 1'b0};
          if (bitn_q == 16'd13) begin
            state_d  = S_TA;
            bitn_d   = '0;
            mdio_t_d = rd_q;
            mdio_o_d = tx_q[31] & ~rd_q;
          end else begin
            bitn_d   = bitn_q + 16'd1;
            mdio_o_d = tx_q[31];
          end
        end
      end

      S_TA: begin
        // Second turnaround bit must be pulled low by the PHY on a read
        if (rise && rd_q && bitn_q == 16'd1) rsp_error_d = mdio_i;
        if (bit_end) begin
          tx_d     = {tx_q[30:0], 1'b0};
          mdio_t_d = rd_q;
          mdio_o_d = tx_q[31] & ~rd_q;
          if (bitn_q == 16'd1) begin
            state_d = S_DATA;
            bitn_d  = '0;
          end else begin
            bitn_d = bitn_q + 16'd1;
          end
        end
      end

      S_DATA: begin
        if (rise && rd_q) rsp_data_d = {rsp_data_q[14:0], mdio_i};
        if (bit_end) begin
          if (bitn_q == 16'd15) begin
            state_d     = S_RESP;
            bitn_d      = '0;
            mdio_t_d    = 1'b1;
            mdio_o_d    = 1'b0;
            rsp_valid_d = 1'b1;
            gap_done_d  = (IDLE_GAP_BITS == 0);
          end else begin
            tx_d     = {tx_q[30:0], 1'b0};
            bitn_d   = bitn_q + 16'd1;
            mdio_t_d = rd_q;
            mdio_o_d = tx_q[31] & ~rd_q;
          end
        end
      end

      // Response hand-off and inter-frame gap run side by side; leave only when both are done
      S_RESP, S_GAP: begin
        if (gap_run && bit_end) begin
          if (bitn_q == GAP_LAST) gap_done_d = 1'b1;
          else                    bitn_d     = bitn_q + 16'd1;
        end
        if (state_q == S_RESP) begin
          if (rsp_take) begin
            rsp_valid_d = 1'b0;
            state_d     = gap_done_d ? S_IDLE : S_GAP;
          end
        end else if (gap_done_d) begin
          state_d = S_IDLE;
        end
      end

      S_REJECT: begin
        if (rsp_take) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign busy      = busy_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;

endmodule

// File: tb/tb_mdio_controller.sv
// Scoreboard bench for mdio_controller with a behavioural PHY on the pad.
module tb_mdio_controller;

  localparam int unsigned H  = 4;
  localparam int unsigned PB = 32;

  logic        clk;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_c45;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_phy_addr, cmd_reg_addr;
  logic [15:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_error, busy, mdc;
  logic [15:0] rsp_data;
  logic        mdio_in, mdio_o, mdio_t;

  mdio_controller #(
    .CLKS_PER_HALF_MDC (H),
    .PREAMBLE_BITS     (PB),
    .SUPPORT_CLAUSE45  (1'b1),
    .IDLE_GAP_BITS     (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_c45      (cmd_c45),
    .cmd_op       (cmd_op),
    .cmd_phy_addr (cmd_phy_addr),
    .cmd_reg_addr (cmd_reg_addr),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_error    (rsp_error),
    .busy         (busy),
    .mdc          (mdc),
    .mdio_i       (mdio_in),
    .mdio_o       (mdio_o),
    .mdio_t       (mdio_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] d;
    logic        e;
    bit          frame;
    logic [63:0] o;
    logic [63:0] t;
  } exp_s;

  exp_s exp_q[$];
  int   nchk = 0;
  int   nerr = 0;

  // PHY model state (written by stimulus)
  logic        phy_en;
  logic [15:0] phy_val;

  // Monitor state
  int          rc;
  int          cyc = 0;
  int          last_end;
  bit          last_end_valid;
  int          end_rc;
  logic        end_mdc, end_t;
  logic [63:0] cap_o, cap_t;
  logic        busy_p, mdc_p, rv_p;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s got=timeout exp=event", name);
  endtask

  function automatic logic phy_bit(input int k);
    if (!phy_en)                        return 1'b1;
    if (k == PB + 15)                   return 1'b0;
    if (k >= PB + 16 && k < PB + 32)    return phy_val[PB + 31 - k];
    return 1'b1;
  endfunction

  // Monitor: tracks MDC bits, drives PHY response, pops scoreboard on each response handshake
  always @(negedge clk) begin
    exp_s e;
    cyc++;
    if (reset) begin
      rc = 0;
      last_end_valid = 1'b0;
      busy_p = 1'b0;
      mdc_p = 1'b0;
      rv_p = 1'b0;
      mdio_in = 1'b1;
    end else begin
      if (busy && !busy_p) begin
        if (last_end_valid) begin
          nchk++;
          if (cyc - last_end < int'(2 * H)) begin
            nerr++;
            $display("FAIL gap got=%0d exp>=%0d", cyc - last_end, 2 * H);
          end
        end
        rc = 0;
        cap_o = '0;
        cap_t = '0;
        mdio_in = phy_bit(0);
      end
      if (mdc && !mdc_p) begin
        if (rc < 64) begin
          cap_o[63 - rc] = mdio_o;
          cap_t[63 - rc] = mdio_t;
        end
        rc++;
      end
      if (!mdc && mdc_p) mdio_in = phy_bit(rc);
      if (rsp_valid && !rv_p) begin
        end_rc  = rc;
        end_mdc = mdc;
        end_t   = mdio_t;
        if (rc != 0) begin
          last_end = cyc;
          last_end_valid = 1'b1;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_rsp got=%0h exp=none", rsp_data);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("t%0d_data", e.id), 64'(rsp_data), 64'(e.d));
          chk($sformatf("t%0d_err", e.id), 64'(rsp_error), 64'(e.e));
          if (e.frame) begin
            chk($sformatf("t%0d_len", e.id), 64'(end_rc), 64'd64);
            chk($sformatf("t%0d_bits_o", e.id), cap_o & ~e.t, e.o & ~e.t);
            chk($sformatf("t%0d_bits_t", e.id), cap_t, e.t);
            chk($sformatf("t%0d_end_mdc_t", e.id), 64'({end_mdc, end_t}), 64'b01);
          end else begin
            chk($sformatf("t%0d_no_mdc", e.id), 64'(rc), 64'd0);
          end
        end
      end
      busy_p = busy;
      mdc_p  = mdc;
      rv_p   = rsp_valid;
    end
  end

  task automatic push(input int id, input logic [15:0] d, input logic e, input bit frame,
                      input logic [63:0] o, input logic [63:0] t);
    exp_s x;
    x.id = id; x.d = d; x.e = e; x.frame = frame; x.o = o; x.t = t;
    exp_q.push_back(x);
  endtask

  task automatic send(input logic c45, input logic [1:0] op, input logic [4:0] phy,
                      input logic [4:0] rg, input logic [15:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_c45 = c45; cmd_op = op; cmd_phy_addr = phy; cmd_reg_addr = rg; cmd_data = d;
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 5000);
    if (!cmd_ready) timeout("send");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 5000);
    if (!cmd_ready) timeout("wait_idle");
  endtask

  localparam logic [63:0] T_RD = {46'h0, 18'h3FFFF};

  initial begin
    int   n;
    int   bad;
    logic [15:0] d0;
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_c45 = 1'b0; cmd_op = '0; cmd_phy_addr = '0; cmd_reg_addr = '0; cmd_data = '0;
    phy_en = 1'b0; phy_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 64'({mdc, mdio_o, mdio_t, cmd_ready, rsp_valid, rsp_error, busy}), 64'b0010000);
    chk("rst_data", 64'(rsp_data), 64'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rdy_after_rst", 64'(cmd_ready), 64'd1);

    // 1: C22 read, PHY returns 0x1234
    phy_en = 1'b1; phy_val = 16'h1234;
    push(1, 16'h1234, 1'b0, 1'b1, {32'hFFFFFFFF, 2'b01, 2'b10, 5'h0C, 5'h02, 18'h0}, T_RD);
    send(1'b0, 2'b10, 5'h0C, 5'h02, 16'h0);
    wait_idle();

    // 2: C22 write 0xA5A5
    push(2, 16'h0, 1'b0, 1'b1, {32'hFFFFFFFF, 2'b01, 2'b01, 5'h0C, 5'h00, 2'b10, 16'hA5A5}, 64'h0);
    send(1'b0, 2'b01, 5'h0C, 5'h00, 16'hA5A5);
    wait_idle();

    // 3: C45 address then C45 read back to back
    phy_val = 16'hBEEF;
    push(3, 16'h0, 1'b0, 1'b1, {32'hFFFFFFFF, 2'b00, 2'b00, 5'h0C, 5'h01, 2'b10, 16'h0007}, 64'h0);
    send(1'b1, 2'b00, 5'h0C, 5'h01, 16'h0007);
    push(4, 16'hBEEF, 1'b0, 1'b1, {32'hFFFFFFFF, 2'b00, 2'b11, 5'h0C, 5'h01, 18'h0}, T_RD);
    send(1'b1, 2'b11, 5'h0C, 5'h01, 16'h0);
    wait_idle();

    // 4: no PHY, pad pulled high
    phy_en = 1'b0;
    push(5, 16'hFFFF, 1'b1, 1'b1, {32'hFFFFFFFF, 2'b01, 2'b10, 5'h0C, 5'h02, 18'h0}, T_RD);
    send(1'b0, 2'b10, 5'h0C, 5'h02, 16'h0);
    wait_idle();

    // 5: response back-pressure for 200 cycles with a competing command
    phy_en = 1'b1; phy_val = 16'h0F0F;
    @(posedge clk); #1; rsp_ready = 1'b0;
    push(6, 16'h0F0F, 1'b0, 1'b1, {32'hFFFFFFFF, 2'b01, 2'b10, 5'h01, 5'h03, 18'h0}, T_RD);
    send(1'b0, 2'b10, 5'h01, 5'h03, 16'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 5000);
    if (!rsp_valid) timeout("t6_rsp_valid");
    d0 = rsp_data;
    @(posedge clk); #1;
    cmd_c45 = 1'b0; cmd_op = 2'b01; cmd_phy_addr = 5'h02; cmd_reg_addr = 5'h04; cmd_data = 16'h5555;
    cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_data == d0 && !cmd_ready)) bad++;
    end
    chk("t6_hold", 64'(bad), 64'd0);
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1; rsp_ready = 1'b1;
    wait_idle();

    // 6: reset mid-DATA of a write, then an invalid C22 op
    send(1'b0, 2'b01, 5'h0C, 5'h00, 16'hFFFF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rc < PB + 20 && n < 5000);
    if (rc < PB + 20) timeout("t7_data_phase");
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t7_rst_mid", 64'({mdio_t, mdc, rsp_valid, busy, cmd_ready}), 64'b10000);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("t7_rdy_held", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("t7_rdy_back", 64'(cmd_ready), 64'd1);
    push(7, 16'h0, 1'b1, 1'b0, 64'h0, 64'h0);
    send(1'b0, 2'b11, 5'h0C, 5'h00, 16'h1111);
    @(negedge clk);
    chk("t8_rej_lat", 64'({rsp_valid, rsp_error}), 64'b11);
    wait_idle();
    push(8, 16'h0, 1'b1, 1'b0, 64'h0, 64'h0);
    send(1'b0, 2'b00, 5'h03, 5'h07, 16'h2222);
    wait_idle();

    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout("scoreboard_drain");
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
